sparse_term_sequencer: RTL

Top-level scheduler directly upstream of `controller`. It zeroes the accumulator memory, then walks the sparse memory and launches one `controller` pass per sparse word. Every multiplication runs exactly `MAX_TERMS` passes: passes beyond the real weight are dummy passes, issued so that runtime does not depend on the secret weight. It owns the controller's start, reset and sparse-address inputs and the accumulator write-redirect select.

---
 rtl/sparse_term_sequencer_pkg.sv | 25 ++
 rtl/sparse_term_sequencer_if.sv | 25 ++
 rtl/sparse_term_sequencer_pass_watchdog.sv | 45 ++++
 rtl/sparse_term_sequencer.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/sparse_term_sequencer_pkg.sv
// Shared constants, state encoding and helpers for the sparse term sequencer.
package sparse_term_sequencer_pkg;

  localparam int MEM_SIZE   = 553;
  localparam int MAX_TERMS  = 50;
  localparam int DUMMY_ADDR = 50;
  localparam int TIMEOUT    = 4095;
  localparam int SPARSE_AW  = 10;
  localparam int WEIGHT_W   = 6;
  localparam int TMO_W      = 12;

  // State encoding, 4 bits wide to line up with the controller's encoding
  localparam logic [3:0] ST_IDLE   = 4'd0;
  localparam logic [3:0] ST_CLEAR  = 4'd1;
  localparam logic [3:0] ST_CRST   = 4'd2;
  localparam logic [3:0] ST_ISSUE  = 4'd3;
  localparam logic [3:0] ST_WAIT   = 4'd4;
  localparam logic [3:0] ST_FINISH = 4'd5;

  // A weight above MAX_TERMS cannot be represented by the pass schedule.
  function automatic logic [WEIGHT_W-1:0] clamp_weight(input logic [WEIGHT_W-1:0] w);
    return (w > WEIGHT_W'(MAX_TERMS)) ? WEIGHT_W'(MAX_TERMS) : w;
  endfunction

endpackage

// File: rtl/sparse_term_sequencer_if.sv
// Bus between the sequencer and the controller / accumulator write mux.
interface sparse_term_sequencer_if;
  import sparse_term_sequencer_pkg::*;

  logic                 ctrl_rst_n;
  logic                 ctrl_start;
  logic [SPARSE_AW-1:0] ctrl_sparse_addr;
  logic                 ctrl_done;
  logic                 acc_dummy_sel;
  logic [SPARSE_AW-1:0] acc_clr_addr;
  logic                 acc_clr_we;

  modport master (
    output ctrl_rst_n, ctrl_start, ctrl_sparse_addr,
    output acc_dummy_sel, acc_clr_addr, acc_clr_we,
    input  ctrl_done
  );

  modport slave (
    input  ctrl_rst_n, ctrl_start, ctrl_sparse_addr,
    input  acc_dummy_sel, acc_clr_addr, acc_clr_we,
    output ctrl_done
  );

endinterface

// File: rtl/sparse_term_sequencer_pass_watchdog.sv
// Per-pass timeout counter and rising-edge detector for the controller's done flag.
module pass_watchdog
  import sparse_term_sequencer_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic arm,
  input  logic done_in,
  output logic done_edge,
  output logic expired
);

  logic [TMO_W-1:0] cnt_q, cnt_d;
  logic             prev_q;

  // Expiry is flagged in the TIMEOUT-th cycle after arming, so the waiting
  // state lasts exactly TIMEOUT cycles; the counter then parks until re-armed.
  assign expired = (cnt_q == TMO_W'(TIMEOUT - 1));

  // The previous-value register samples continuously, so a done flag that is
  // still high while the pass is being issued never reads as a fresh edge.
  assign done_edge = done_in & ~prev_q;

  // Restart on arm, otherwise count up until expiry
  always_comb begin
    cnt_d = cnt_q;
    if (arm) begin
      cnt_d = '0;
    end else if (!expired) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Counter and edge-history registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      prev_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      prev_q <= done_in;
    end
  end

endmodule

// File: rtl/sparse_term_sequencer.sv
// Clears the accumulator, then runs MAX_TERMS controller passes (real then dummy)
// so that total runtime never depends on the secret weight.
module sparse_term_sequencer
  import sparse_term_sequencer_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [WEIGHT_W-1:0] weight,
  sparse_term_sequencer_if.master bus,
  output logic [WEIGHT_W-1:0] term_idx,
  output logic                busy,
  output logic                done,
  output logic                error
);

  localparam logic [SPARSE_AW-1:0] CLR_LAST  = SPARSE_AW'(MEM_SIZE - 1);
  localparam logic [WEIGHT_W-1:0]  LAST_TERM = WEIGHT_W'(MAX_TERMS - 1);

  logic [3:0]           state_q, state_d;
  logic [WEIGHT_W-1:0]  weight_q, weight_d;
  logic [WEIGHT_W-1:0]  term_q, term_d;
  logic [SPARSE_AW-1:0] clr_addr_q, clr_addr_d;
  logic                 clr_we_q, clr_we_d;
  logic                 crst_q, crst_d;
  logic                 start_q, start_d;
  logic                 rstn_q, rstn_d;
  logic [SPARSE_AW-1:0] saddr_q, saddr_d;
  logic                 dsel_q, dsel_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 error_q, error_d;
  logic                 done_edge, expired;

  pass_watchdog u_watchdog (
    .clk      (clk),
    .rst_n    (rst_n),
    .arm      (state_q == ST_ISSUE),
    .done_in  (bus.ctrl_done),
    .done_edge(done_edge),
    .expired  (expired)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state selection; a done edge wins over a simultaneous timeout
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (start) state_d = ST_CLEAR;
      ST_CLEAR:  if (clr_addr_q == CLR_LAST) state_d = ST_CRST;
      ST_CRST:   if (crst_q) state_d = ST_ISSUE;
      ST_ISSUE:  state_d = ST_WAIT;
      ST_WAIT: begin
        if (done_edge)    state_d = (term_q == LAST_TERM) ? ST_FINISH : ST_CRST;
        else if (expired) state_d = ST_FINISH;
      end
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Next values of counters and outputs, derived from the upcoming state so
  // every output is a flop that already matches the state it belongs to
  always_comb begin
    weight_d   = weight_q;
    term_d     = term_q;
    error_d    = error_q;
    saddr_d    = saddr_q;
    dsel_d     = dsel_q;
    crst_d     = (state_q == ST_CRST) ? ~crst_q : 1'b0;
    clr_addr_d = '0;
    if ((state_q == ST_CLEAR) && (state_d == ST_CLEAR)) clr_addr_d = clr_addr_q + 1'b1;
    clr_we_d   = (state_d == ST_CLEAR);
    start_d    = (state_d == ST_ISSUE);
    rstn_d     = !((state_d == ST_CRST) || (state_d == ST_FINISH));
    busy_d     = (state_d != ST_IDLE) && (state_d != ST_FINISH);
    done_d     = (state_d == ST_FINISH);
    if ((state_q == ST_IDLE) && start) begin
      weight_d = clamp_weight(weight);
      term_d   = '0;
      error_d  = 1'b0;
    end
    if ((state_q == ST_WAIT) && done_edge && (term_q != LAST_TERM)) term_d = term_q + 1'b1;
    if ((state_q == ST_WAIT) && !done_edge && expired) error_d = 1'b1;
    // Address and redirect are fixed at issue time and held through the wait
    if (state_d == ST_ISSUE) begin
      saddr_d = (term_q < weight_q) ? SPARSE_AW'(term_q) : SPARSE_AW'(DUMMY_ADDR);
      dsel_d  = (term_q >= weight_q);
    end else if ((state_d == ST_FINISH) || (state_d == ST_IDLE)) begin
      dsel_d  = 1'b0;
    end
  end

  // Datapath and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      weight_q   <= '0;
      term_q     <= '0;
      clr_addr_q <= '0;
      clr_we_q   <= 1'b0;
      crst_q     <= 1'b0;
      start_q    <= 1'b0;
      rstn_q     <= 1'b0;
      saddr_q    <= '0;
      dsel_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      weight_q   <= weight_d;
      term_q     <= term_d;
      clr_addr_q <= clr_addr_d;
      clr_we_q   <= clr_we_d;
      crst_q     <= crst_d;
      start_q    <= start_d;
      rstn_q     <= rstn_d;
      saddr_q    <= saddr_d;
      dsel_q     <= dsel_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      error_q    <= error_d;
    end
  end

  assign bus.ctrl_rst_n       = rstn_q;
  assign bus.ctrl_start       = start_q;
  assign bus.ctrl_sparse_addr = saddr_q;
  assign bus.acc_dummy_sel    = dsel_q;
  assign bus.acc_clr_addr     = clr_addr_q;
  assign bus.acc_clr_we       = clr_we_q;
  assign term_idx             = term_q;
  assign busy                 = busy_q;
  assign done                 = done_q;
  assign error                = error_q;

endmodule
